mips_alu: RTL and testbench



---
 rtl/mips_alu.sv | 93 +++++++++
 tb/tb_mips_alu.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/mips_alu.sv
// MIPS-R2000 execute-stage ALU: operand-B mux, combinational operation select,
// and EX/MEM registers for the result, zero flag and signed-overflow flag.
module mips_alu #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned CTRL_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WIDTH-1:0]  op_1,
  input  logic [WIDTH-1:0]  data_2,
  input  logic [WIDTH-1:0]  sign_ext,
  input  logic              sel,
  output logic [WIDTH-1:0]  op_2,
  input  logic [CTRL_W-1:0] ALU_ctrl,
  output logic              zero,
  output logic [WIDTH-1:0]  res,
  output logic              ovf
);

  localparam int unsigned ShW = $clog2(WIDTH);

  localparam logic [CTRL_W-1:0] CtrlAnd  = CTRL_W'(0);
  localparam logic [CTRL_W-1:0] CtrlOr   = CTRL_W'(1);
  localparam logic [CTRL_W-1:0] CtrlAdd  = CTRL_W'(2);
  localparam logic [CTRL_W-1:0] CtrlXor  = CTRL_W'(3);
  localparam logic [CTRL_W-1:0] CtrlSub  = CTRL_W'(6);
  localparam logic [CTRL_W-1:0] CtrlSlt  = CTRL_W'(7);
  localparam logic [CTRL_W-1:0] CtrlSltu = CTRL_W'(8);
  localparam logic [CTRL_W-1:0] CtrlSll  = CTRL_W'(9);
  localparam logic [CTRL_W-1:0] CtrlSrl  = CTRL_W'(10);
  localparam logic [CTRL_W-1:0] CtrlSra  = CTRL_W'(11);
  localparam logic [CTRL_W-1:0] CtrlNor  = CTRL_W'(12);

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic [ShW-1:0]   shamt;
  logic [WIDTH-1:0] res_d;
  logic             ovf_d;
  logic [WIDTH-1:0] res_q;
  logic             zero_q;
  logic             ovf_q;

  assign op_2  = sel ? sign_ext : data_2;
  assign sum   = op_1 + op_2;
  assign diff  = op_1 - op_2;
  // Only the low bits of op_1 form the shift amount; upper bits are ignored.
  assign shamt = op_1[ShW-1:0];

  always_comb begin
    res_d = '0;
    ovf_d = 1'b0;
    case (ALU_ctrl)
      CtrlAnd:  res_d = op_1 & op_2;
      CtrlOr:   res_d = op_1 | op_2;
      CtrlAdd: begin
        res_d = sum;
        ovf_d = (op_1[WIDTH-1] == op_2[WIDTH-1]) && (sum[WIDTH-1] != op_1[WIDTH-1]);
      end
      CtrlXor:  res_d = op_1 ^ op_2;
      CtrlSub: begin
        res_d = diff;
        ovf_d = (op_1[WIDTH-1] != op_2[WIDTH-1]) && (diff[WIDTH-1] != op_1[WIDTH-1]);
      end
      CtrlSlt:  res_d = {{(WIDTH-1){1'b0}}, ($signed(op_1) < $signed(op_2))};
      CtrlSltu: res_d = {{(WIDTH-1){1'b0}}, (op_1 < op_2)};
      CtrlSll:  res_d = op_2 << shamt;
      CtrlSrl:  res_d = op_2 >> shamt;
      CtrlSra:  res_d = WIDTH'($signed(op_2) >>> shamt);
      CtrlNor:  res_d = ~(op_1 | op_2);
      default: begin
        res_d = '0;
        ovf_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q  <= '0;
      zero_q <= 1'b1;
      ovf_q  <= 1'b0;
    end else begin
      res_q  <= res_d;
      zero_q <= (res_d == '0);
      ovf_q  <= ovf_d;
    end
  end

  assign res  = res_q;
  assign zero = zero_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_mips_alu.sv
// Directed-vector bench for mips_alu with hand-computed expected results.
module tb_mips_alu;

  logic        clk;
  logic        rst_n;
  logic [31:0] op_1;
  logic [31:0] data_2;
  logic [31:0] sign_ext;
  logic        sel;
  logic [31:0] op_2;
  logic [3:0]  ALU_ctrl;
  logic        zero;
  logic [31:0] res;
  logic        ovf;

  int total;
  int bad;

  mips_alu #(.WIDTH(32), .CTRL_W(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .op_1     (op_1),
    .data_2   (data_2),
    .sign_ext (sign_ext),
    .sel      (sel),
    .op_2     (op_2),
    .ALU_ctrl (ALU_ctrl),
    .zero     (zero),
    .res      (res),
    .ovf      (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // Drive one operation, check op_2 combinationally, then the registered outputs.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] se, input logic s, input logic [3:0] ctrl,
                        input logic [31:0] exp_res, input logic exp_ovf);
    logic [31:0] exp_op2;
    op_1     = a;
    data_2   = d;
    sign_ext = se;
    sel      = s;
    ALU_ctrl = ctrl;
    exp_op2  = s ? se : d;
    #1;
    check({tag, ".op_2"}, op_2, exp_op2);
    @(posedge clk);
    #1;
    check({tag, ".res"}, res, exp_res);
    check({tag, ".zero"}, {31'd0, zero}, {31'd0, exp_res == 32'd0});
    check({tag, ".ovf"}, {31'd0, ovf}, {31'd0, exp_ovf});
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    rst_n    = 1'b0;
    op_1     = 32'd0;
    data_2   = 32'd0;
    sign_ext = 32'd0;
    sel      = 1'b0;
    ALU_ctrl = 4'd0;

    repeat (2) @(posedge clk);
    #1;
    check("rst.res", res, 32'd0);
    check("rst.zero", {31'd0, zero}, 32'd1);
    check("rst.ovf", {31'd0, ovf}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // sel=0: op_2 = data_2 = 2
    run_op("and0",  32'd1, 32'd2, 32'd3, 1'b0, 4'd0,  32'd0,          1'b0);
    run_op("or0",   32'd1, 32'd2, 32'd3, 1'b0, 4'd1,  32'd3,          1'b0);
    run_op("add0",  32'd1, 32'd2, 32'd3, 1'b0, 4'd2,  32'd3,          1'b0);
    run_op("sub0",  32'd1, 32'd2, 32'd3, 1'b0, 4'd6,  32'hFFFFFFFF,   1'b0);
    run_op("slt0",  32'd1, 32'd2, 32'd3, 1'b0, 4'd7,  32'd1,          1'b0);
    run_op("nor0",  32'd1, 32'd2, 32'd3, 1'b0, 4'd12, 32'hFFFFFFFC,   1'b0);
    // sel=1: op_2 = sign_ext = 3
    run_op("and1",  32'd1, 32'd2, 32'd3, 1'b1, 4'd0,  32'd1,          1'b0);
    run_op("or1",   32'd1, 32'd2, 32'd3, 1'b1, 4'd1,  32'd3,          1'b0);
    run_op("add1",  32'd1, 32'd2, 32'd3, 1'b1, 4'd2,  32'd4,          1'b0);
    run_op("sub1",  32'd1, 32'd2, 32'd3, 1'b1, 4'd6,  32'hFFFFFFFE,   1'b0);
    run_op("slt1",  32'd1, 32'd2, 32'd3, 1'b1, 4'd7,  32'd1,          1'b0);
    run_op("nor1",  32'd1, 32'd2, 32'd3, 1'b1, 4'd12, 32'hFFFFFFFC,   1'b0);
    // Overflow and signed/unsigned boundaries
    run_op("addov", 32'h7FFFFFFF, 32'd1, 32'd0, 1'b0, 4'd2, 32'h80000000, 1'b1);
    run_op("addnv", 32'h80000000, 32'h80000000, 32'd0, 1'b0, 4'd2, 32'd0, 1'b1);
    run_op("sub55", 32'd5, 32'd5, 32'd0, 1'b0, 4'd6, 32'd0, 1'b0);
    run_op("subov", 32'h80000000, 32'd0, 32'd1, 1'b1, 4'd6, 32'h7FFFFFFF, 1'b1);
    run_op("sltm1", 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0, 4'd7, 32'd1, 1'b0);
    run_op("sltum1",32'hFFFFFFFF, 32'd1, 32'd0, 1'b0, 4'd8, 32'd0, 1'b0);
    run_op("sltmin",32'h80000000, 32'd0, 32'd0, 1'b0, 4'd7, 32'd1, 1'b0);
    run_op("sltumn",32'h80000000, 32'd0, 32'd0, 1'b0, 4'd8, 32'd0, 1'b0);
    run_op("xor",   32'h0000F0F0, 32'h0000FF00, 32'd0, 1'b0, 4'd3, 32'h00000FF0, 1'b0);
    // Shifts: op_1[4:0] is the amount
    run_op("sra",   32'd4, 32'h80000000, 32'd0, 1'b0, 4'd11, 32'hF8000000, 1'b0);
    run_op("srl",   32'd4, 32'h80000000, 32'd0, 1'b0, 4'd10, 32'h08000000, 1'b0);
    run_op("sll0",  32'd0, 32'h00001234, 32'd0, 1'b0, 4'd9,  32'h00001234, 1'b0);
    run_op("sllhi", 32'h00000020, 32'd1, 32'd0, 1'b0, 4'd9, 32'd1, 1'b0);
    run_op("sll4",  32'h00000024, 32'd1, 32'd0, 1'b0, 4'd9, 32'h00000010, 1'b0);
    run_op("sraps", 32'd31, 32'h40000000, 32'd0, 1'b0, 4'd11, 32'd0, 1'b0);
    // Undefined codes
    run_op("udf15", 32'd5, 32'd7, 32'd0, 1'b0, 4'd15, 32'd0, 1'b0);
    run_op("udf4",  32'h7FFFFFFF, 32'd1, 32'd0, 1'b0, 4'd4, 32'd0, 1'b0);

    // Asynchronous reset between edges after a nonzero result
    run_op("prerst", 32'd1, 32'd2, 32'd3, 1'b0, 4'd1, 32'd3, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst.res", res, 32'd0);
    check("arst.zero", {31'd0, zero}, 32'd1);
    check("arst.ovf", {31'd0, ovf}, 32'd0);
    sel = 1'b1;
    #1;
    check("arst.op_2s1", op_2, 32'd3);
    sel = 1'b0;
    #1;
    check("arst.op_2s0", op_2, 32'd2);
    @(posedge clk);
    #1;
    check("hold.res", res, 32'd0);
    check("hold.zero", {31'd0, zero}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("postrst", 32'd1, 32'd2, 32'd3, 1'b1, 4'd2, 32'd4, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
